// File: rtl/core_pkg.sv
// core_pkg: shared state encodings and widths for the core memory port arbiter.
package core_pkg;
    localparam int ADDR_W = 16;
    localparam int WORD_W = 32;
    localparam logic [1:0] ARB_IDLE  = 2'b00;
    localparam logic [1:0] ARB_FETCH = 2'b01;
    localparam logic [1:0] ARB_DATA  = 2'b10;
    typedef enum logic [1:0] {
        S_IDLE  = ARB_IDLE,
        S_FETCH = ARB_FETCH,
        S_DATA  = ARB_DATA
    } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-port signals around the arbiter.
interface mem_port_arbiter_if;
    import core_pkg::*;
    logic              f_req, f_gnt, f_valid, hold;
    logic [ADDR_W-1:0] f_addr;
    logic              d_req, d_we, d_gnt, d_valid;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic [WORD_W-1:0] rdata;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata, mem_rdata;
    logic [3:0]        mem_be;
    modport master (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        output f_gnt, f_valid, d_gnt, d_valid, hold, rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
    modport slave (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        input  f_gnt, f_valid, d_gnt, d_valid, hold, rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core memory port between fetch and load/store,
// data first, with a starvation bound that forces fetch through.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               a_rst,
    mem_port_arbiter_if.master bus
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    arb_state_t        r_state, w_next;
    logic              w_arb, w_f, w_d, w_gf, w_gd;
    logic              r_f_gnt, r_d_gnt, r_f_valid, r_d_valid, r_mem_req, r_mem_we;
    logic [3:0]        r_starve, r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata, r_rdata;

    // A request whose grant is showing this cycle is the one already being served.
    always_comb begin
        w_arb  = (r_state == S_IDLE) | bus.mem_ack;
        w_f    = bus.f_req & ~r_f_gnt;
        w_d    = bus.d_req & ~r_d_gnt;
        w_gf   = w_arb & w_f & (~w_d | (r_starve == LIM));
        w_gd   = w_arb & w_d & ~w_gf;
        w_next = w_gf ? S_FETCH : w_gd ? S_DATA : w_arb ? S_IDLE : r_state;
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_f_gnt     <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_f_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_starve    <= '0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_f_gnt   <= w_gf;
            r_d_gnt   <= w_gd;
            r_f_valid <= bus.mem_ack & (r_state == S_FETCH);
            r_d_valid <= bus.mem_ack & (r_state == S_DATA);
            if (bus.mem_ack & ((r_state == S_FETCH) | ((r_state == S_DATA) & ~r_mem_we)))
                r_rdata <= bus.mem_rdata;
            if (w_gf)
                r_starve <= '0;
            else if (w_gd & w_f & (r_starve != LIM))
                r_starve <= r_starve + 4'd1;
            if (w_gf | w_gd) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= w_gd & bus.d_we;
                r_mem_addr <= (w_gf ? bus.f_addr : bus.d_addr) & ~ADDR_W'(3);
                r_mem_be   <= w_gf ? 4'hF : bus.d_be;
                if (w_gd) r_mem_wdata <= bus.d_wdata;
            end else if (w_arb) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    assign bus.f_gnt     = r_f_gnt;
    assign bus.d_gnt     = r_d_gnt;
    assign bus.f_valid   = r_f_valid;
    assign bus.d_valid   = r_d_valid;
    assign bus.rdata     = r_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.hold      = (bus.f_req | (r_state == S_FETCH)) & ~r_f_valid;
endmodule
